// File: rtl/mac_accum_4x4_if.sv
// Operand-stream and result handshake bundle for mac_accum_4x4.
// The master drives operands and result acceptance; the slave (the MAC) drives
// operand readiness and the frame result.
interface mac_accum_4x4_if #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/mac_accum_4x4.sv
// Frame-based multiply-accumulate: 4x4 Wallace-tree product registered in
// stage P, summed into a saturating accumulator in stage A, frame total held
// on a valid/ready output until taken.

// 4x4 unsigned multiplier: four partial-product rows reduced by two layers of
// 3:2 carry-save compressors, then one carry-propagate add.
module mul4x4_wallace (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    logic [7:0] pp0, pp1, pp2, pp3;
    logic [7:0] s1, c1, s2, c2;

    // Partial products and carry-save reduction tree
    always_comb begin
        pp0 = {4'b0000, a_i & {4{b_i[0]}}};
        pp1 = {3'b000,  a_i & {4{b_i[1]}}, 1'b0};
        pp2 = {2'b00,   a_i & {4{b_i[2]}}, 2'b00};
        pp3 = {1'b0,    a_i & {4{b_i[3]}}, 3'b000};
        s1  = pp0 ^ pp1 ^ pp2;
        c1  = ((pp0 & pp1) | (pp0 & pp2) | (pp1 & pp2)) << 1;
        s2  = s1 ^ c1 ^ pp3;
        c2  = ((s1 & c1) | (s1 & pp3) | (c1 & pp3)) << 1;
        p_o = s2 + c2;
    end
endmodule

module mac_accum_4x4 #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mac_accum_4x4_if.slave bus
);
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [7:0]       prod;
    logic [7:0]       p_prod_q;
    logic             p_last_q;
    logic             p_valid_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fovf_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_data_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;

    logic             accept;
    logic [SUM_W-1:0] sum;
    logic             add_ovf;
    logic [ACC_W-1:0] acc_sat;
    logic [CNT_W-1:0] cnt_inc;

    mul4x4_wallace u_mul (
        .a_i (bus.in_a),
        .b_i (bus.in_b),
        .p_o (prod)
    );

    // A closing term sitting in stage P blocks the next frame from entering
    assign bus.in_ready  = (state_q == RUN) && !(p_valid_q && p_last_q);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

    // Saturating add of the staged product and saturating term count
    always_comb begin
        sum     = {1'b0, acc_q} + SUM_W'(p_prod_q);
        add_ovf = sum[ACC_W];
        acc_sat = add_ovf ? '1 : sum[ACC_W-1:0];
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state logic: close a frame into HOLD, release on result handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (p_valid_q && p_last_q) state_d = HOLD;
            HOLD:    if (out_valid_q && bus.out_ready) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // Stage P: register the product of each accepted operand pair
    always_ff @(posedge clk) begin
        if (rst) begin
            p_prod_q  <= '0;
            p_last_q  <= 1'b0;
            p_valid_q <= 1'b0;
        end else begin
            p_valid_q <= accept;
            if (accept) begin
                p_prod_q <= prod;
                p_last_q <= bus.in_last;
            end
        end
    end

    // Stage A: accumulate the frame and publish its total on the closing term
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            fovf_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
            if (p_valid_q) begin
                if (p_last_q) begin
                    out_data_q  <= acc_sat;
                    out_count_q <= cnt_inc;
                    out_ovf_q   <= fovf_q | add_ovf;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    fovf_q      <= 1'b0;
                end else begin
                    acc_q  <= acc_sat;
                    cnt_q  <= cnt_inc;
                    fovf_q <= fovf_q | add_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_accum_4x4.sv
// Directed and scoreboarded checks of the frame MAC.
module tb_mac_accum_4x4;
    localparam int ACC_W = 12;
    localparam int CNT_W = 8;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    mac_accum_4x4_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mac_accum_4x4 #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       last;
        int         gap;
        int         ed;
        int         ec;
        int         eo;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input logic last);
        int unsigned guard = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        while (!bus.in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!bus.in_ready) timeout_fail("in_ready");
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input string name, input int ed, input int ec, input int eo);
        int unsigned guard = 0;
        while (!bus.out_valid && guard < 100) begin
            step();
            guard++;
        end
        if (!bus.out_valid) begin
            timeout_fail(name);
        end else begin
            check({name, ".data"}, bus.out_data, ed);
            check({name, ".count"}, bus.out_count, ec);
            check({name, ".ovf"}, bus.out_ovf, eo);
            check({name, ".in_ready_hold"}, bus.in_ready, 0);
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            check({name, ".valid_drop"}, bus.out_valid, 0);
            check({name, ".in_ready_rise"}, bus.in_ready, 1);
        end
    endtask

    task automatic get_result_rand(input int ed, input int ec, input int eo);
        int unsigned guard = 0;
        bit seen = 0;
        bit hs = 0;
        while (!hs && guard < 200) begin
            if (bus.out_valid && !seen) begin
                check("rand.data", bus.out_data, ed);
                check("rand.count", bus.out_count, ec);
                check("rand.ovf", bus.out_ovf, eo);
                seen = 1;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            hs = bus.out_valid && bus.out_ready;
            step();
            guard++;
        end
        bus.out_ready = 1'b0;
        if (!hs) timeout_fail("rand.result");
        else check("rand.valid_drop", bus.out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd3,  4'd5,  1'b0, 0, 0,   0, 0};
        tbl[1]  = '{4'd7,  4'd2,  1'b0, 0, 0,   0, 0};
        tbl[2]  = '{4'd15, 4'd15, 1'b0, 0, 0,   0, 0};
        tbl[3]  = '{4'd0,  4'd9,  1'b1, 0, 254, 4, 0};
        tbl[4]  = '{4'd5,  4'd5,  1'b0, 0, 0,   0, 0};
        tbl[5]  = '{4'd6,  4'd6,  1'b1, 2, 61,  2, 0};
        tbl[6]  = '{4'd1,  4'd1,  1'b1, 0, 1,   1, 0};
        tbl[7]  = '{4'd15, 4'd15, 1'b0, 1, 0,   0, 0};
        tbl[8]  = '{4'd15, 4'd15, 1'b1, 0, 450, 2, 0};
        tbl[9]  = '{4'd0,  4'd0,  1'b1, 0, 0,   1, 0};
        tbl[10] = '{4'd15, 4'd1,  1'b0, 0, 0,   0, 0};
        tbl[11] = '{4'd2,  4'd8,  1'b1, 1, 31,  2, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst.out_valid", bus.out_valid, 0);
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.out_data", bus.out_data, 0);
        check("rst.out_count", bus.out_count, 0);
        check("rst.out_ovf", bus.out_ovf, 0);

        for (int i = 0; i < 12; i++) begin
            repeat (tbl[i].gap) step();
            send_pair(tbl[i].a, tbl[i].b, tbl[i].last);
            if (tbl[i].last) get_result($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].ec, tbl[i].eo);
        end

        bus.out_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                send_pair(4'(a), 4'(b), 1'b1);
                check("exh.early", bus.out_valid, 0);
                step();
                check("exh.valid", bus.out_valid, 1);
                check("exh.data", bus.out_data, a * b);
                check("exh.count", bus.out_count, 1);
                check("exh.ovf", bus.out_ovf, 0);
                step();
                check("exh.drop", bus.out_valid, 0);
            end
        end
        bus.out_ready = 1'b0;

        repeat (19) send_pair(4'd15, 4'd15, 1'b0);
        send_pair(4'd15, 4'd15, 1'b1);
        get_result("sat", ACC_MAX, 20, 1);
        send_pair(4'd2, 4'd3, 1'b1);
        get_result("after_sat", 6, 1, 0);

        send_pair(4'd4, 4'd4, 1'b1);
        step();
        bus.in_valid = 1'b1;
        bus.in_a     = 4'd15;
        bus.in_b     = 4'd15;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp.valid", bus.out_valid, 1);
            check("bp.data", bus.out_data, 16);
            check("bp.in_ready", bus.in_ready, 0);
            step();
        end
        bus.in_valid = 1'b0;
        get_result("bp", 16, 1, 0);
        send_pair(4'd1, 4'd1, 1'b1);
        get_result("after_bp", 1, 1, 0);

        repeat (CNT_MAX + 4) send_pair(4'd0, 4'd0, 1'b0);
        send_pair(4'd1, 4'd1, 1'b1);
        get_result("cnt_sat", 1, CNT_MAX, 0);

        send_pair(4'd9, 4'd9, 1'b0);
        send_pair(4'd9, 4'd9, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort.no_valid", bus.out_valid, 0);
            check("abort.in_ready", bus.in_ready, 1);
            step();
        end
        send_pair(4'd2, 4'd2, 1'b1);
        get_result("abort", 4, 1, 0);

        send_pair(4'd3, 4'd3, 1'b1);
        step();
        step();
        check("rst_hold.pre", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_hold.valid", bus.out_valid, 0);
        check("rst_hold.data", bus.out_data, 0);
        check("rst_hold.in_ready", bus.in_ready, 1);

        for (int f = 0; f < 25; f++) begin
            int len;
            int s;
            int ov;
            len = int'($urandom_range(1, 5));
            s = 0;
            ov = 0;
            for (int k = 0; k < len; k++) begin
                logic [3:0] a;
                logic [3:0] b;
                a = 4'($urandom_range(0, 15));
                b = 4'($urandom_range(0, 15));
                if (f % 5 == 4) begin
                    a = 4'd15;
                    b = 4'd15;
                    len = 5;
                end
                s = s + int'(a) * int'(b);
                if (s > ACC_MAX) begin
                    s = ACC_MAX;
                    ov = 1;
                end
                repeat ($urandom_range(0, 2)) step();
                send_pair(a, b, k == len - 1);
            end
            get_result_rand(s, len, ov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
